uart_rx: RTL and testbench

- Parameterised UART receiver: oversamples the serial line RX_IN and reassembles one frame into an 8-bit parallel byte.
- Frame format: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Sits at the serial input of the system; drives the parallel data and the data-valid flag to the system controller/synchronizer.

---
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, start + 8 data (LSB first) + optional parity + stop.
// Ports:
//   CLK        - oversampling clock, all logic on its rising edge
//   RST        - asynchronous active-high reset
//   PAR_TYP    - parity type, 1 = odd, 0 = even
//   PAR_EN     - 1 = frame carries a parity bit after the data bits
//   Prescale   - clock cycles per bit (8, 16 or 32)
//   RX_IN      - serial line, idles high
//   P_DATA     - last correctly received byte
//   DATA_Valid - high while P_DATA holds a freshly accepted frame
module uart_rx #(
    parameter int PRESCALE = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PAR_TYP,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       RX_IN,
    output logic [7:0] P_DATA,
    output logic       DATA_Valid
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state_q, state_d;
    logic [5:0] edge_q, edge_d;
    logic [2:0] bit_q, bit_d;
    logic [2:0] samp_q, samp_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       par_err_q, par_err_d;
    logic       valid_q, valid_d;
    logic [5:0] ps;
    logic [5:0] half;
    logic       wrap;
    logic       decide;
    logic       vote;

    // A zero ratio would never wrap; fall back to the default instead.
    assign ps     = (Prescale == 6'd0) ? 6'(PRESCALE) : Prescale;
    assign half   = ps >> 1;
    assign wrap   = edge_q == ps - 6'd1;
    // All three mid-bit samples are registered by this count.
    assign decide = edge_q == half + 6'd2;
    assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    always_comb begin
        state_d   = state_q;
        edge_d    = (state_q == IDLE || wrap) ? 6'd0 : edge_q + 6'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        par_err_d = par_err_q;
        valid_d   = valid_q;
        samp_d[0] = (edge_q == half - 6'd1) ? RX_IN : samp_q[0];
        samp_d[1] = (edge_q == half)        ? RX_IN : samp_q[1];
        samp_d[2] = (edge_q == half + 6'd1) ? RX_IN : samp_q[2];
        case (state_q)
            IDLE: state_d = RX_IN ? IDLE : START;
            START: begin
                if (decide && vote) begin
                    state_d = IDLE;
                    edge_d  = 6'd0;
                end else begin
                    if (decide) begin
                        valid_d   = 1'b0;
                        par_err_d = 1'b0;
                    end
                    if (wrap) state_d = DATA;
                end
            end
            DATA: begin
                if (decide) shift_d = {vote, shift_q[7:1]};
                if (wrap) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (decide) par_err_d = vote != (^shift_q ^ PAR_TYP);
                if (wrap) state_d = STOP;
            end
            STOP: begin
                // Leave mid-stop-bit so a following start edge is not missed.
                if (decide) begin
                    state_d = IDLE;
                    edge_d  = 6'd0;
                    if (vote && (!par_err_q || !PAR_EN)) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            edge_q    <= 6'd0;
            bit_q     <= 3'd0;
            samp_q    <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            par_err_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            par_err_q <= par_err_d;
            valid_q   <= valid_d;
        end
    end

    assign P_DATA     = data_q;
    assign DATA_Valid = valid_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, hand-sequenced and randomized checks of uart_rx.
module tb_uart_rx;
    logic       CLK = 1'b0;
    logic       RST;
    logic       PAR_TYP;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       RX_IN;
    logic [7:0] P_DATA;
    logic       DATA_Valid;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] m_data;
    logic       m_valid;

    typedef struct {
        logic       en;
        logic       typ;
        logic [5:0] ps;
        logic [7:0] dat;
        logic       pbit;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t tv[9];

    uart_rx #(.PRESCALE(16)) dut (
        .CLK(CLK), .RST(RST), .PAR_TYP(PAR_TYP), .PAR_EN(PAR_EN),
        .Prescale(Prescale), .RX_IN(RX_IN), .P_DATA(P_DATA), .DATA_Valid(DATA_Valid)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bit_out(input logic b, input int n);
        RX_IN = b;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic body(input logic [7:0] d, input logic pb, input logic stop);
        int p = int'(Prescale);
        for (int i = 0; i < 8; i++) bit_out(d[i], p);
        if (PAR_EN) bit_out(pb, p);
        bit_out(stop, p);
    endtask

    task automatic frame(input logic [7:0] d, input logic pb, input logic stop);
        bit_out(1'b0, int'(Prescale));
        body(d, pb, stop);
    endtask

    // Odd parity: total count of ones (data + parity) is odd; even: it is even.
    function automatic logic accept(input logic [7:0] d, input logic en, input logic typ,
                                    input logic pb, input logic stop);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (en) ones += int'(pb);
        return stop && (!en || (ones % 2) == (typ ? 1 : 0));
    endfunction

    initial begin
        logic [7:0] d;
        logic       pb;
        logic       st;
        tv[0] = '{1'b1, 1'b1, 6'd16, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
        tv[1] = '{1'b1, 1'b0, 6'd16, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1};
        tv[2] = '{1'b0, 1'b0, 6'd16, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1};
        tv[3] = '{1'b1, 1'b1, 6'd16, 8'hA5, 1'b0, 1'b1, 8'h3C, 1'b0};
        tv[4] = '{1'b1, 1'b1, 6'd16, 8'h5A, 1'b1, 1'b0, 8'h3C, 1'b0};
        tv[5] = '{1'b1, 1'b1, 6'd8,  8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
        tv[6] = '{1'b1, 1'b1, 6'd32, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
        tv[7] = '{1'b1, 1'b0, 6'd8,  8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1};
        tv[8] = '{1'b0, 1'b1, 6'd32, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0};
        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 6'd16;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset data", P_DATA, 8'h00);
        chk("reset valid", {7'd0, DATA_Valid}, 8'h00);
        RST = 1'b0;
        bit_out(1'b1, 4);
        for (int i = 0; i < 9; i++) begin
            PAR_EN = tv[i].en; PAR_TYP = tv[i].typ; Prescale = tv[i].ps;
            frame(tv[i].dat, tv[i].pbit, tv[i].stop);
            chk($sformatf("vec%0d data", i), P_DATA, tv[i].exp_data);
            chk($sformatf("vec%0d valid", i), {7'd0, DATA_Valid}, {7'd0, tv[i].exp_valid});
            bit_out(1'b1, 2 * int'(tv[i].ps));
        end
        // Valid level holds through idle and drops once the next start is confirmed.
        PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd16;
        frame(8'hA5, 1'b0, 1'b1);
        bit_out(1'b1, 16);
        chk("even idle data", P_DATA, 8'hA5);
        chk("even idle valid", {7'd0, DATA_Valid}, 8'h01);
        bit_out(1'b0, 16);
        chk("start clears valid", {7'd0, DATA_Valid}, 8'h00);
        body(8'h81, 1'b0, 1'b1);
        chk("after start data", P_DATA, 8'h81);
        chk("after start valid", {7'd0, DATA_Valid}, 8'h01);
        // A short low pulse is a glitch: nothing changes and the next frame is clean.
        PAR_TYP = 1'b1;
        bit_out(1'b0, 3);
        bit_out(1'b1, 32);
        chk("glitch data", P_DATA, 8'h81);
        chk("glitch valid", {7'd0, DATA_Valid}, 8'h01);
        frame(8'h6E, 1'b0, 1'b1);
        chk("post glitch data", P_DATA, 8'h6E);
        chk("post glitch valid", {7'd0, DATA_Valid}, 8'h01);
        // Break: line low for many frames, then released; receiver must recover.
        bit_out(1'b0, 25 * 16);
        chk("break data", P_DATA, 8'h6E);
        chk("break valid", {7'd0, DATA_Valid}, 8'h00);
        bit_out(1'b1, 12 * 16);
        frame(8'hC3, 1'b1, 1'b1);
        chk("post break data", P_DATA, 8'hC3);
        chk("post break valid", {7'd0, DATA_Valid}, 8'h01);
        // Asynchronous reset in the middle of data bit 4.
        bit_out(1'b0, 16);
        for (int i = 0; i < 4; i++) bit_out(i[0], 16);
        bit_out(1'b1, 5);
        RST = 1'b1;
        #1;
        chk("mid reset data", P_DATA, 8'h00);
        chk("mid reset valid", {7'd0, DATA_Valid}, 8'h00);
        bit_out(1'b1, 3);
        RST = 1'b0;
        bit_out(1'b1, 8);
        frame(8'h3C, 1'b1, 1'b1);
        chk("post reset data", P_DATA, 8'h3C);
        chk("post reset valid", {7'd0, DATA_Valid}, 8'h01);
        m_data = 8'h3C;
        m_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            PAR_EN = 1'($urandom_range(0, 1));
            PAR_TYP = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: Prescale = 6'd8;
                1: Prescale = 6'd16;
                default: Prescale = 6'd32;
            endcase
            d = 8'($urandom);
            pb = 1'($urandom_range(0, 1));
            st = $urandom_range(0, 5) != 0;
            frame(d, pb, st);
            if (accept(d, PAR_EN, PAR_TYP, pb, st)) begin
                m_data = d;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            chk($sformatf("rand%0d data", n), P_DATA, m_data);
            chk($sformatf("rand%0d valid", n), {7'd0, DATA_Valid}, {7'd0, m_valid});
            bit_out(1'b1, st ? int'($urandom_range(1, 3)) : 2 * int'(Prescale));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
